// File: rtl/avalon_pwm_ctrl_if.sv
// Avalon-MM slave bus bundle for avalon_pwm_ctrl (word-addressed, no waitrequest).
interface avalon_pwm_ctrl_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/avalon_pwm_ctrl.sv
// Avalon-MM control stage driving period/duty_cycle of a downstream PWM generator.
// Optional macro PWM_CTRL_IRQ_EN enables CTRL.irq_en and the irq output.
module avalon_pwm_ctrl #(
  parameter logic [31:0] RESET_PERIOD = 32'd999,
  parameter logic [31:0] RESET_DUTY   = 32'd0
) (
  input  logic               clk,
  input  logic               reset,
  avalon_pwm_ctrl_if.slave   bus,
  output logic [31:0]        period,
  output logic [31:0]        duty_cycle,
  output logic               irq
);

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PERIOD = 2'd1,
    REG_DUTY   = 2'd2,
    REG_STATUS = 2'd3
  } reg_addr_e;

`ifdef PWM_CTRL_IRQ_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] sper_q, sper_d;
  logic [31:0] sduty_q, sduty_d;
  logic [31:0] aper_q, aper_d;
  logic [31:0] aduty_q, aduty_d;
  logic        pend_q, pend_d;
  logic        flag_q, flag_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] duty_q, duty_d;
  logic        boundary;
  logic        commit;

  assign boundary = (cnt_q > aper_q);
  assign commit   = pend_q && (boundary || ctrl_q[1]);

  always_comb begin
    ctrl_d  = ctrl_q;
    sper_d  = sper_q;
    sduty_d = sduty_q;
    aper_d  = aper_q;
    aduty_d = aduty_q;
    pend_d  = pend_q;
    flag_d  = flag_q;
    rdata_d = rdata_q;
    cnt_d   = boundary ? '0 : cnt_q + 32'd1;

    // Commit uses pre-write staging; a same-cycle staging write re-arms pending below.
    if (commit) begin
      aper_d  = sper_q;
      aduty_d = sduty_q;
      pend_d  = 1'b0;
    end

    if (bus.read) begin
      case (reg_addr_e'(bus.address))
        REG_CTRL:   rdata_d = {29'd0, ctrl_q};
        REG_PERIOD: rdata_d = sper_q;
        REG_DUTY:   rdata_d = sduty_q;
        REG_STATUS: rdata_d = {30'd0, flag_q, pend_q};
        default:    rdata_d = '0;
      endcase
    end

    if (bus.write) begin
      case (reg_addr_e'(bus.address))
        REG_CTRL: ctrl_d = bus.writedata[2:0] & CTRL_MASK;
        REG_PERIOD: begin
          sper_d = bus.writedata;
          if (ctrl_q[1]) aper_d = bus.writedata;
          else           pend_d = 1'b1;
        end
        REG_DUTY: begin
          sduty_d = bus.writedata;
          if (ctrl_q[1]) aduty_d = bus.writedata;
          else           pend_d  = 1'b1;
        end
        REG_STATUS: if (bus.writedata[1]) flag_d = 1'b0;
        default: ;
      endcase
    end

    if (boundary) flag_d = 1'b1;

    // Gate from next-state values so duty_cycle tracks active duty on the same edge.
    duty_d = ctrl_d[0] ? aduty_d : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= '0;
      sper_q  <= RESET_PERIOD;
      sduty_q <= RESET_DUTY;
      aper_q  <= RESET_PERIOD;
      aduty_q <= RESET_DUTY;
      pend_q  <= 1'b0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      duty_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      sper_q  <= sper_d;
      sduty_q <= sduty_d;
      aper_q  <= aper_d;
      aduty_q <= aduty_d;
      pend_q  <= pend_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      duty_q  <= duty_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign period       = aper_q;
  assign duty_cycle   = duty_q;

`ifdef PWM_CTRL_IRQ_EN
  assign irq = flag_q & ctrl_q[2];
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_pwm_ctrl.sv
// Self-checking bench for avalon_pwm_ctrl: register-level model plus directed checks.
module tb_avalon_pwm_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] period, duty_cycle;
  logic        irq;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          cmp_en = 1'b0;

  avalon_pwm_ctrl_if bus_if ();

  avalon_pwm_ctrl #(
    .RESET_PERIOD(32'd999),
    .RESET_DUTY  (32'd0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .period    (period),
    .duty_cycle(duty_cycle),
    .irq       (irq)
  );

  always #5 clk = ~clk;

`ifdef PWM_CTRL_IRQ_EN
  localparam logic [2:0] M_MASK = 3'b111;
`else
  localparam logic [2:0] M_MASK = 3'b011;
`endif

  // Model state: software-visible registers and the position within the PWM period.
  logic [2:0]  m_ctrl;
  logic [31:0] m_sper, m_sduty, m_aper, m_aduty, m_cnt, m_rd, m_duty;
  logic        m_pend, m_flag;

  function automatic logic [31:0] m_regread(input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_ctrl};
      2'd1:    return m_sper;
      2'd2:    return m_sduty;
      default: return {30'd0, m_flag, m_pend};
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ctrl = '0; m_sper = 32'd999; m_sduty = '0; m_aper = 32'd999; m_aduty = '0;
      m_cnt = '0; m_rd = '0; m_duty = '0; m_pend = 1'b0; m_flag = 1'b0;
    end else begin
      logic        at_end;
      logic [2:0]  n_ctrl;
      logic [31:0] n_sper, n_sduty, n_aper, n_aduty;
      logic        n_pend, n_flag;
      at_end = (m_cnt > m_aper);
      n_ctrl = m_ctrl; n_sper = m_sper; n_sduty = m_sduty;
      n_aper = m_aper; n_aduty = m_aduty; n_pend = m_pend; n_flag = m_flag;
      if (m_pend && (at_end || m_ctrl[1])) begin
        n_aper = m_sper; n_aduty = m_sduty; n_pend = 1'b0;
      end
      if (bus_if.read) m_rd = m_regread(bus_if.address);
      if (bus_if.write) begin
        case (bus_if.address)
          2'd0: n_ctrl = bus_if.writedata[2:0] & M_MASK;
          2'd1: begin n_sper = bus_if.writedata;
                  if (m_ctrl[1]) n_aper = bus_if.writedata; else n_pend = 1'b1; end
          2'd2: begin n_sduty = bus_if.writedata;
                  if (m_ctrl[1]) n_aduty = bus_if.writedata; else n_pend = 1'b1; end
          default: if (bus_if.writedata[1]) n_flag = 1'b0;
        endcase
      end
      if (at_end) n_flag = 1'b1;
      m_cnt  = at_end ? 32'd0 : m_cnt + 32'd1;
      m_ctrl = n_ctrl; m_sper = n_sper; m_sduty = n_sduty;
      m_aper = n_aper; m_aduty = n_aduty; m_pend = n_pend; m_flag = n_flag;
      m_duty = m_ctrl[0] ? m_aduty : 32'd0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("model_period", period, m_aper);
      check("model_duty", duty_cycle, m_duty);
      check("model_readdata", bus_if.readdata, m_rd);
`ifdef PWM_CTRL_IRQ_EN
      check("model_irq", {31'd0, irq}, {31'd0, m_flag & m_ctrl[2]});
`else
      check("model_irq", {31'd0, irq}, 32'd0);
`endif
    end
  end

  // Each call occupies one clock; entered and left at 1ns after a rising edge.
  task automatic bus_cycle(input bit wr, input bit rd, input logic [1:0] a, input logic [31:0] d);
    bus_if.write = wr; bus_if.read = rd; bus_if.address = a; bus_if.writedata = d;
    @(posedge clk); #1;
    bus_if.write = 1'b0; bus_if.read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_cycle(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus_cycle(1'b0, 1'b1, a, '0);
    d = bus_if.readdata;
  endtask

  task automatic wait_cnt(input logic [31:0] n);
    int g = 0;
    while (m_cnt != n && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    if (m_cnt != n) check("wait_cnt_timeout", m_cnt, n);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] d;
    bus_if.address = '0; bus_if.read = 1'b0; bus_if.write = 1'b0; bus_if.writedata = '0;
    #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    cmp_en = 1'b1;

    // Reset values.
    rd(2'd0, d); check("rst_ctrl", d, 32'd0);
    rd(2'd1, d); check("rst_period_reg", d, 32'd999);
    rd(2'd2, d); check("rst_duty_reg", d, 32'd0);
    rd(2'd3, d); check("rst_status", d, 32'd0);
    check("rst_period_out", period, 32'd999);
    check("rst_duty_out", duty_cycle, 32'd0);

    // Deferred commit with period 9 active and enable set.
    wr(2'd0, 32'h3);
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h1);
    check("imm_period9", period, 32'd9);
    wait_cnt(32'd3);
    wr(2'd1, 32'd19);
    wr(2'd2, 32'd5);
    rd(2'd3, d); check("def_pending_set", d & 32'h1, 32'h1);
    check("def_hold_period", period, 32'd9);
    check("def_hold_duty", duty_cycle, 32'd0);
    wait_cnt(32'd10);
    check("def_pre_period", period, 32'd9);
    check("def_pre_duty", duty_cycle, 32'd0);
    idle();
    check("def_post_period", period, 32'd19);
    check("def_post_duty", duty_cycle, 32'd5);
    rd(2'd3, d); check("def_pending_clr", d & 32'h1, 32'h0);

    // Staging write in the exact boundary cycle.
    wr(2'd2, 32'd4);
    wait_cnt(32'd20);
    wr(2'd2, 32'd3);
    check("col_duty4", duty_cycle, 32'd4);
    check("col_period", period, 32'd19);
    rd(2'd3, d); check("col_pending", d & 32'h1, 32'h1);
    wait_cnt(32'd20);
    idle();
    check("col_duty3", duty_cycle, 32'd3);

    // Immediate mode.
    wr(2'd0, 32'h3);
    wr(2'd2, 32'd7);
    check("imm_duty7", duty_cycle, 32'd7);
    rd(2'd3, d); check("imm_no_pending", d & 32'h1, 32'h0);
    wr(2'd0, 32'h2);
    check("imm_disable", duty_cycle, 32'd0);

    // Switching to immediate while a deferred update is pending.
    wr(2'd0, 32'h1);
    wr(2'd1, 32'd30);
    wr(2'd0, 32'h3);
    idle();
    check("pend_imm_period", period, 32'd30);
    wr(2'd0, 32'h1);

    // boundary_flag W1C and set-wins-over-clear.
    wait_cnt(32'd5);
    wr(2'd3, 32'h2);
    rd(2'd3, d); check("flag_cleared", d & 32'h2, 32'h0);
    wait_cnt(32'd31);
    wr(2'd3, 32'h2);
    rd(2'd3, d); check("flag_set_wins", d & 32'h2, 32'h2);

`ifdef PWM_CTRL_IRQ_EN
    wr(2'd0, 32'h5);
    check("irq_on_flag", {31'd0, irq}, 32'd1);
    wait_cnt(32'd5);
    wr(2'd3, 32'h2);
    check("irq_w1c", {31'd0, irq}, 32'd0);
    wait_cnt(32'd31);
    idle();
    check("irq_rise", {31'd0, irq}, 32'd1);
    rd(2'd0, d); check("irq_ctrl_read", d, 32'h5);
`else
    wr(2'd0, 32'h5);
    rd(2'd0, d); check("noirq_ctrl_read", d, 32'h1);
    check("noirq_irq", {31'd0, irq}, 32'd0);
`endif

    // Asynchronous reset mid-operation.
    reset = 1'b1;
    #1;
    check("areset_period", period, 32'd999);
    check("areset_duty", duty_cycle, 32'd0);
    check("areset_readdata", bus_if.readdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rd(2'd1, d); check("areset_period_reg", d, 32'd999);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
